// File: rtl/noc_rr_port_arbiter.sv
// noc_rr_port_arbiter
// Round-robin packet arbiter for one NoC router output port with 4 requesters.
// A grant is held for a whole packet, which ends on the beat flagged last.
// The arbiter always spends one idle arbitration cycle between packets.
// Optional per-requester packet counters are enabled by defining ARB_GRANT_CNT_EN.
module noc_rr_port_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req_valid,
   input  logic [3:0] req_last,
   output logic [3:0] req_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       busy
`ifdef ARB_GRANT_CNT_EN
   ,
   input  logic                 cnt_clr,
   output logic [4*CNT_W-1:0]   grant_cnt
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] grant_next;
   logic [1:0] sel_next;
   logic [1:0] rr_ptr;
   logic [1:0] rr_ptr_next;
   logic [1:0] winner;
   logic       any_req;
   logic       done;

   // A counter width of zero is meaningless; stop elaboration early.
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("noc_rr_port_arbiter: CNT_W must be at least 1");
   end

   // Round-robin search: first valid requester scanning from rr_ptr upward, mod 4.
   always_comb begin : search
      logic [1:0] idx;
      winner  = 2'd0;
      any_req = 1'b0;
      idx     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (!any_req && req_valid[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

   // Packet completes when the owner's last beat is accepted downstream.
   assign done = (state == LOCK) && req_valid[sel] && out_ready && req_last[sel];

   // Next-state logic: arbitrate in IDLE, hold ownership in LOCK until the last beat.
   always_comb begin
      state_next  = state;
      grant_next  = grant;
      sel_next    = sel;
      rr_ptr_next = rr_ptr;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = LOCK;
               grant_next = 4'b0001 << winner;
               sel_next   = winner;
            end
         end
         LOCK: begin
            if (done) begin
               state_next  = IDLE;
               grant_next  = 4'b0000;
               sel_next    = 2'd0;
               rr_ptr_next = sel + 2'd1;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = 4'b0000;
            sel_next   = 2'd0;
         end
      endcase
   end

   // State, grant and pointer registers; reset abandons any packet in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         grant  <= 4'b0000;
         sel    <= 2'd0;
         rr_ptr <= 2'd0;
      end else begin
         state  <= state_next;
         grant  <= grant_next;
         sel    <= sel_next;
         rr_ptr <= rr_ptr_next;
      end
   end

   // Handshake outputs are combinational from the registered grant only.
   assign busy      = (state == LOCK);
   assign out_valid = busy && req_valid[sel];
   assign req_ready = busy ? (grant & {4{out_ready}}) : 4'b0000;

`ifdef ARB_GRANT_CNT_EN
   for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt;

      // Saturating count of completed packets for this requester; clear has priority.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (cnt_clr) begin
            cnt <= '0;
         end else if (done && (sel == 2'(gi)) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign grant_cnt[gi*CNT_W +: CNT_W] = cnt;
   end
`endif

endmodule

// File: tb/tb_noc_rr_port_arbiter.sv
// Directed testbench for noc_rr_port_arbiter (counter checks when ARB_GRANT_CNT_EN is defined).
module tb_noc_rr_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_valid;
   logic [3:0] req_last;
   logic [3:0] req_ready;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
`ifdef ARB_GRANT_CNT_EN
   logic       cnt_clr;
   logic [7:0] grant_cnt;
`endif

   int errors = 0;
   int checks = 0;

   noc_rr_port_arbiter #(.CNT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant     (grant),
      .sel       (sel),
      .busy      (busy)
`ifdef ARB_GRANT_CNT_EN
      ,
      .cnt_clr   (cnt_clr),
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] g;
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      out_ready = 1'b1;
`ifdef ARB_GRANT_CNT_EN
      cnt_clr   = 1'b0;
`endif
      #3 rst_n = 1'b0;
      tick();
      tick();
      // Reset held with all requesting
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_grant", 32'(grant), 32'h1);
      chk("post_rst_sel", 32'(sel), 32'h0);

      // All 4 requesting single-beat packets: 0,1,2,3,0,1 each followed by one idle cycle
      for (int k = 0; k < 6; k++) begin
         g = 4'b0001 << (k % 4);
         chk($sformatf("rr_grant_%0d", k), 32'(grant), 32'(g));
         chk($sformatf("rr_sel_%0d", k), 32'(sel), 32'(k % 4));
         chk($sformatf("rr_out_valid_%0d", k), 32'(out_valid), 32'h1);
         chk($sformatf("rr_req_ready_%0d", k), 32'(req_ready), 32'(g));
         tick();
         chk($sformatf("rr_idle_grant_%0d", k), 32'(grant), 32'h0);
         chk($sformatf("rr_idle_busy_%0d", k), 32'(busy), 32'h0);
         if (k != 5) tick();
      end

      // rr_ptr = 2 now: requester 2 sends 3 beats while requester 1 waits
      req_valid = 4'b0110;
      req_last  = 4'b0000;
      tick();
      chk("p3_grant_b1", 32'(grant), 32'h4);
      chk("p3_req_ready_b1", 32'(req_ready), 32'h4);
      tick();
      out_ready = 1'b0;
      #1;
      chk("p3_grant_stall", 32'(grant), 32'h4);
      chk("p3_req_ready_stall", 32'(req_ready), 32'h0);
      chk("p3_out_valid_stall", 32'(out_valid), 32'h1);
      tick();
      out_ready = 1'b1;
      #1;
      chk("p3_grant_b2", 32'(grant), 32'h4);
      chk("p3_req_ready_b2", 32'(req_ready), 32'h4);
      tick();
      req_last = 4'b0100;
      #1;
      chk("p3_grant_b3", 32'(grant), 32'h4);
      tick();
      chk("p3_idle_grant", 32'(grant), 32'h0);
      req_last = 4'b0000;
      tick();
      chk("p3_next_grant", 32'(grant), 32'h2);
      chk("p3_next_sel", 32'(sel), 32'h1);
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      tick();
      chk("p3_done_grant", 32'(grant), 32'h0);

      // rr_ptr = 2: owner 3 drops valid for 2 cycles mid-packet
      req_valid = 4'b1000;
      req_last  = 4'b0000;
      tick();
      chk("p4_grant", 32'(grant), 32'h8);
      tick();
      req_valid = 4'b0111;
      #1;
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("p4_gap_out_valid_%0d", c), 32'(out_valid), 32'h0);
         chk($sformatf("p4_gap_grant_%0d", c), 32'(grant), 32'h8);
         chk($sformatf("p4_gap_busy_%0d", c), 32'(busy), 32'h1);
         chk($sformatf("p4_gap_req_ready_%0d", c), 32'(req_ready), 32'h8);
         tick();
      end
      req_valid = 4'b1000;
      req_last  = 4'b1000;
      #1;
      chk("p4_resume_out_valid", 32'(out_valid), 32'h1);
      tick();
      chk("p4_done_grant", 32'(grant), 32'h0);

      // rr_ptr = 0: one packet from 1 moves rr_ptr to 2
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      tick();
      chk("p5_pre_grant", 32'(grant), 32'h2);
      tick();
      // 4-beat packet from 2, reset during beat 2
      req_valid = 4'b0100;
      req_last  = 4'b0000;
      tick();
      chk("p5_grant", 32'(grant), 32'h4);
      tick();
      rst_n = 1'b0;
      #1;
      chk("p5_async_grant", 32'(grant), 32'h0);
      chk("p5_async_sel", 32'(sel), 32'h0);
      chk("p5_async_out_valid", 32'(out_valid), 32'h0);
      chk("p5_async_req_ready", 32'(req_ready), 32'h0);
      chk("p5_async_busy", 32'(busy), 32'h0);
      req_valid = 4'b1010;
      tick();
      chk("p5_hold_grant", 32'(grant), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("p5_after_grant", 32'(grant), 32'h2);
      chk("p5_after_sel", 32'(sel), 32'h1);
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      tick();
      chk("p5_done_grant", 32'(grant), 32'h0);

`ifdef ARB_GRANT_CNT_EN
      chk("cnt1_one", 32'(grant_cnt[3:2]), 32'h1);
      req_valid = 4'b0001;
      req_last  = 4'b0001;
      for (int n = 1; n <= 5; n++) begin
         tick();
         chk($sformatf("cnt_pkt_grant_%0d", n), 32'(grant), 32'h1);
         tick();
         chk($sformatf("cnt0_after_%0d", n), 32'(grant_cnt[1:0]), 32'((n > 3) ? 3 : n));
      end
      tick();
      chk("cnt_clr_grant", 32'(grant), 32'h1);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("cnt_clr_wins", 32'(grant_cnt), 32'h0);
      chk("cnt_clr_idle", 32'(grant), 32'h0);
`endif

      req_valid = 4'b0000;
      tick();
      chk("final_idle_grant", 32'(grant), 32'h0);
      chk("final_idle_out_valid", 32'(out_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/noc_rr_port_arbiter.md
Name: noc_rr_port_arbiter

Overview:
- Round-robin packet arbiter for one router output port in the hierarchical mesh NoC.
- Shares the output port among 4 input requesters (index 0..3).
- Holds each grant for a whole packet, which ends on the beat flagged last.
- Drives a one-hot grant and a 2-bit binary select; the select feeds the router's 4:1 data mux and its 2-bit index encoder.

Parameters:
CNT_W, 16, width of per-requester grant counters (used only with ARB_GRANT_CNT_EN)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  4  per-requester beat valid
req_last  input  4  per-requester last-beat-of-packet flag, qualified by req_valid
req_ready  output  4  per-requester beat accepted; at most one bit set
out_valid  output  1  beat valid toward output port
out_ready  input  1  downstream can accept beat
grant  output  4  registered one-hot owner; 0 when idle
sel  output  2  binary index of grant (0001->0, 0010->1, 0100->2, 1000->3); 0 when idle
busy  output  1  1 while in LOCK

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, grant = 0, sel = 0, rr_ptr = 0, busy = 0.
  - out_valid = 0, req_ready = 0.
  - Counters = 0.
- Reset mid-packet abandons the packet immediately. Recovery is the upstream's responsibility.
- State IDLE:
  - out_valid = 0, req_ready = 0.
  - If any req_valid is set, choose the first set bit scanning rr_ptr, rr_ptr+1, … mod 4.
  - Next edge: load grant/sel with the winner, state = LOCK.
  - If no req_valid is set, stay in IDLE.
- State LOCK (owner k = sel):
  - out_valid = req_valid[k]; req_ready[k] = out_ready; all other req_ready bits = 0. These are combinational from the registered grant.
  - Beat transfer occurs when req_valid[k] && out_ready.
  - Transfer with req_last[k] = 1: next edge sets grant = 0, sel = 0, state = IDLE, rr_ptr = (k+1) mod 4.
  - Owner deasserting req_valid mid-packet: stay in LOCK, out_valid = 0. No other requester may be granted.
  - out_ready = 0: hold all state, no transfer.
- Latency:
  - 1 cycle from req_valid (in IDLE) to grant.
  - One idle arbitration cycle between consecutive packets, including back-to-back packets from the same requester.
- Fairness:
  - rr_ptr advances only on packet completion.
  - With all 4 requesting continuously, the grant order from reset is 0,1,2,3,0…
- Single-beat packet (req_last on the first beat): LOCK lasts exactly the cycles until that beat transfers.
- req_last of non-owners is ignored.
- grant is always one-hot or zero. sel always matches grant.

Optional Feature:
- Macro ARB_GRANT_CNT_EN.
- When defined:
  - Adds input cnt_clr (1) and output grant_cnt (4*CNT_W). Counter for requester i occupies bits [i*CNT_W +: CNT_W].
  - Counter i increments by 1 on each packet completion by requester i and saturates at all-ones.
  - cnt_clr = 1 zeroes all counters on the next edge. If cnt_clr and a completion coincide, the clear wins.
- When undefined: those ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset with req_valid = 4'b1111 held -> grant = 0, sel = 0, out_valid = 0 while rst_n = 0. After release: grant = 0001 one cycle later, sel = 0.
- All 4 requesting 1-beat packets, out_ready = 1 -> grants 0001, 0010, 0100, 1000, 0001, each packet followed by 1 idle cycle.
- Requester 2 sends a 3-beat packet while requester 1 also requests; out_ready toggles 1,0,1,1 -> grant stays 0100 until beat 3 transfers; req_ready[1] = 0 throughout; requester 1 is granted next.
- Owner 3 drops req_valid for 2 cycles mid-packet -> out_valid = 0, grant stays 1000, busy = 1, no other requester is granted.
- Assert rst_n = 0 during beat 2 of a 4-beat packet -> all outputs 0 asynchronously; rr_ptr = 0, so with 4'b1010 requesting, the next grant is 0010.
- ARB_GRANT_CNT_EN with CNT_W = 2: requester 0 completes 5 packets -> grant_cnt[1:0] = 3 (saturated). Then cnt_clr coincident with a completion -> 0.
